// File: rtl/axi_fft_pkg.sv
// axi_fft_pkg: shared definitions for the axi_fft output path.
//   fft_state_t        - output controller frame state
//   OVF_CNT_W          - width of the saturating overflow counter
//   elements_addr_size - buffer word address width for a given log2 FFT size
package axi_fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } fft_state_t;

    localparam int unsigned OVF_CNT_W = 16;

    // A frame is 2**nfft complex points, each stored as two 32-bit words (RE, IM).
    function automatic int unsigned elements_addr_size(input int unsigned nfft);
        return $clog2((2 ** nfft) * 2);
    endfunction

endpackage

// File: rtl/fft_output_ctrl_arbiter.sv
// fft_port_arbiter: shares the output buffer's async read port between the
// host single-word reader (fixed priority) and the frame drain engine.
//   clk, reset       - clock, synchronous active-high reset
//   host_req/addr    - host single-word read request and address
//   drain_idx        - next word index the drain engine wants
//   drain_active     - drain engine is in its fetching state
//   m_axis_tvalid/
//   m_axis_tready    - current stream output handshake state
//   buf_rdata        - async buffer data for buf_raddr
//   buf_raddr        - buffer read address (combinational)
//   host_rdata/rvalid- registered host read result, one cycle after host_req
//   fetch            - drain engine may load buf_rdata into its output stage
module fft_port_arbiter #(
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          host_req,
    input  logic [AW-1:0] host_addr,
    input  logic [AW-1:0] drain_idx,
    input  logic          drain_active,
    input  logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    input  logic [31:0]   buf_rdata,
    output logic [AW-1:0] buf_raddr,
    output logic [31:0]   host_rdata,
    output logic          host_rvalid,
    output logic          fetch
);

    always_comb begin
        buf_raddr = host_req ? host_addr : drain_idx;
    end

    // Output stage is free when empty or when its current beat leaves this cycle.
    always_comb begin
        fetch = drain_active && !host_req && (!m_axis_tvalid || m_axis_tready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            host_rdata  <= '0;
            host_rvalid <= 1'b0;
        end else begin
            host_rvalid <= host_req;
            if (host_req) begin
                host_rdata <= buf_rdata;
            end
        end
    end

endmodule

// File: rtl/fft_output_ctrl.sv
// fft_output_ctrl: owns the FFT output buffer read port, tracks frame
// availability, drains frames onto an AXI-Stream master and serves host reads.
//   clk, reset        - clock, synchronous active-high reset
//   buf_raddr/rdata   - buffer async read port
//   buf_received      - one-cycle pulse: buffer holds a new frame
//   cfg_auto_drain    - start draining as soon as a frame is ready
//   cfg_start         - start drain (READY only)
//   cfg_discard       - drop held frame (READY only)
//   host_req/addr     - host single-word read
//   host_rdata/rvalid - host read result, latency 1
//   m_axis_*          - AXI-Stream master (tlast on word N_ELEMENTS-1)
//   frame_ready       - frame held and not yet consumed
//   busy              - drain in progress (DRAIN or FLUSH)
//   drain_done        - pulse after the tlast beat is accepted
//   overflow_cnt      - saturating count of frames overwritten before consumption
module fft_output_ctrl
    import axi_fft_pkg::*;
#(
    parameter int unsigned NFFT               = 3,
    parameter int unsigned POINT_SIZE         = 2 ** NFFT,
    parameter int unsigned N_ELEMENTS         = POINT_SIZE * 2,
    parameter int unsigned ELEMENTS_ADDR_SIZE = elements_addr_size(NFFT)
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [ELEMENTS_ADDR_SIZE-1:0] buf_raddr,
    input  logic [31:0]                   buf_rdata,
    input  logic                          buf_received,
    input  logic                          cfg_auto_drain,
    input  logic                          cfg_start,
    input  logic                          cfg_discard,
    input  logic                          host_req,
    input  logic [ELEMENTS_ADDR_SIZE-1:0] host_addr,
    output logic [31:0]                   host_rdata,
    output logic                          host_rvalid,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [31:0]                   m_axis_tdata,
    output logic                          m_axis_tlast,
    output logic                          frame_ready,
    output logic                          busy,
    output logic                          drain_done,
    output logic [OVF_CNT_W-1:0]          overflow_cnt
);

    localparam logic [ELEMENTS_ADDR_SIZE-1:0] LAST_IDX = ELEMENTS_ADDR_SIZE'(N_ELEMENTS - 1);

    fft_state_t                    state;
    logic [ELEMENTS_ADDR_SIZE-1:0] drain_idx;
    logic                          fetch;
    logic                          beat_acc;
    logic                          flush_done;
    logic                          ovf_evt;
    // A frame arrived during FLUSH: after completion it is the held frame.
    logic                          pend;

    fft_port_arbiter #(
        .AW (ELEMENTS_ADDR_SIZE)
    ) u_arb (
        .clk           (clk),
        .reset         (reset),
        .host_req      (host_req),
        .host_addr     (host_addr),
        .drain_idx     (drain_idx),
        .drain_active  (state == DRAIN),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .buf_rdata     (buf_rdata),
        .buf_raddr     (buf_raddr),
        .host_rdata    (host_rdata),
        .host_rvalid   (host_rvalid),
        .fetch         (fetch)
    );

    always_comb begin
        beat_acc   = m_axis_tvalid && m_axis_tready;
        flush_done = (state == FLUSH) && beat_acc && m_axis_tlast;
        ovf_evt    = buf_received &&
                     ((state == READY) || (state == DRAIN) || ((state == FLUSH) && !flush_done));
        busy       = (state == DRAIN) || (state == FLUSH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            drain_idx     <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            frame_ready   <= 1'b0;
            drain_done    <= 1'b0;
            overflow_cnt  <= '0;
            pend          <= 1'b0;
        end else begin
            drain_done <= 1'b0;

            // A fetch refills the output stage in the same cycle the old beat leaves.
            if (fetch) begin
                m_axis_tdata  <= buf_rdata;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= (drain_idx == LAST_IDX);
            end else if (beat_acc) begin
                m_axis_tvalid <= 1'b0;
            end

            if (ovf_evt && (overflow_cnt != '1)) begin
                overflow_cnt <= overflow_cnt + 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (buf_received) begin
                        state       <= READY;
                        frame_ready <= 1'b1;
                    end
                end
                READY: begin
                    if (cfg_start || cfg_auto_drain) begin
                        state     <= DRAIN;
                        drain_idx <= '0;
                        pend      <= 1'b0;
                    end else if (cfg_discard) begin
                        state       <= IDLE;
                        frame_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (fetch) begin
                        if (drain_idx == LAST_IDX) begin
                            drain_idx <= '0;
                            state     <= FLUSH;
                        end else begin
                            drain_idx <= drain_idx + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_done) begin
                        drain_done <= 1'b1;
                        pend       <= 1'b0;
                        if (buf_received || pend) begin
                            state       <= READY;
                            frame_ready <= 1'b1;
                        end else begin
                            state       <= IDLE;
                            frame_ready <= 1'b0;
                        end
                    end else if (buf_received) begin
                        pend <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_output_ctrl.sv
// tb_fft_output_ctrl: directed self-checking bench for fft_output_ctrl (NFFT=3).
// Buffer model: word k holds 0x1000 + k.
module tb_fft_output_ctrl;

    localparam int unsigned AW = 4;

    logic          clk;
    logic          reset;
    logic [AW-1:0] buf_raddr;
    logic [31:0]   buf_rdata;
    logic          buf_received;
    logic          cfg_auto_drain;
    logic          cfg_start;
    logic          cfg_discard;
    logic          host_req;
    logic [AW-1:0] host_addr;
    logic [31:0]   host_rdata;
    logic          host_rvalid;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [31:0]   m_axis_tdata;
    logic          m_axis_tlast;
    logic          frame_ready;
    logic          busy;
    logic          drain_done;
    logic [15:0]   overflow_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    fft_output_ctrl #(
        .NFFT (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .buf_raddr      (buf_raddr),
        .buf_rdata      (buf_rdata),
        .buf_received   (buf_received),
        .cfg_auto_drain (cfg_auto_drain),
        .cfg_start      (cfg_start),
        .cfg_discard    (cfg_discard),
        .host_req       (host_req),
        .host_addr      (host_addr),
        .host_rdata     (host_rdata),
        .host_rvalid    (host_rvalid),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tlast   (m_axis_tlast),
        .frame_ready    (frame_ready),
        .busy           (busy),
        .drain_done     (drain_done),
        .overflow_cnt   (overflow_cnt)
    );

    assign buf_rdata = 32'h1000 + 32'(buf_raddr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_received();
        buf_received = 1'b1;
        tick();
        buf_received = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tvalid"}, m_axis_tvalid, 0);
        chk({tag, "_tdata"}, m_axis_tdata, 0);
        chk({tag, "_tlast"}, m_axis_tlast, 0);
        chk({tag, "_frame_ready"}, frame_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_drain_done"}, drain_done, 0);
        chk({tag, "_overflow"}, overflow_cnt, 0);
        chk({tag, "_host_rvalid"}, host_rvalid, 0);
        chk({tag, "_host_rdata"}, host_rdata, 0);
        chk({tag, "_raddr"}, buf_raddr, 0);
    endtask

    // Stream sink. mode 0: tready=1; 1: tready 1,0,0 repeating; 2: tready=1 with
    // host reads of address 5 on every other cycle. Stops after max_beats beats.
    task automatic drain(input int mode, input int max_beats, input bit recv_at_last,
                         input int exp_dones);
        int          beats     = 0;
        int          dones     = 0;
        int          cyc       = 0;
        logic        hold_v    = 1'b0;
        logic [31:0] hold_d    = '0;
        logic        hold_l    = 1'b0;
        logic        host_pend = 1'b0;
        while (cyc < 200) begin
            if (mode == 2) begin
                chk("host_rvalid", host_rvalid, host_pend);
                if (host_pend) chk("host_rdata", host_rdata, 32'h1005);
            end
            if (hold_v) begin
                chk("stall_tvalid", m_axis_tvalid, 1);
                chk("stall_tdata", m_axis_tdata, hold_d);
                chk("stall_tlast", m_axis_tlast, hold_l);
            end
            if (mode == 0 && beats > 0 && beats < max_beats)
                chk("back_to_back", m_axis_tvalid, 1);
            if (drain_done) dones++;
            if (beats == max_beats) break;

            m_axis_tready = (mode == 1) ? (cyc % 3 == 0) : 1'b1;
            host_req      = (mode == 2) && (cyc % 2 == 0);
            host_addr     = 4'd5;
            host_pend     = host_req;
            buf_received  = recv_at_last && m_axis_tvalid && m_axis_tready && m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                chk("beat_data", m_axis_tdata, 32'h1000 + 32'(beats));
                chk("beat_last", m_axis_tlast, (beats == 15));
                beats++;
            end
            hold_v = m_axis_tvalid && !m_axis_tready;
            hold_d = m_axis_tdata;
            hold_l = m_axis_tlast;
            tick();
            cyc++;
        end
        host_req      = 1'b0;
        buf_received  = 1'b0;
        m_axis_tready = 1'b0;
        chk("beat_count", beats, max_beats);
        chk("done_count", dones, exp_dones);
    endtask

    initial begin
        reset          = 1'b1;
        buf_received   = 1'b0;
        cfg_auto_drain = 1'b0;
        cfg_start      = 1'b0;
        cfg_discard    = 1'b0;
        host_req       = 1'b0;
        host_addr      = '0;
        m_axis_tready  = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();

        // Basic auto drain
        cfg_auto_drain = 1'b1;
        pulse_received();
        chk("basic_ready", frame_ready, 1);
        chk("basic_tvalid0", m_axis_tvalid, 0);
        tick();
        chk("basic_busy", busy, 1);
        chk("basic_tvalid1", m_axis_tvalid, 0);
        drain(0, 16, 1'b0, 1);
        chk("basic_frame_ready", frame_ready, 0);
        chk("basic_busy_end", busy, 0);
        chk("basic_ovf", overflow_cnt, 0);
        chk("basic_tvalid_end", m_axis_tvalid, 0);

        // Backpressure
        pulse_received();
        tick();
        drain(1, 16, 1'b0, 1);
        chk("bp_frame_ready", frame_ready, 0);
        chk("bp_tvalid_end", m_axis_tvalid, 0);

        // Host contention
        pulse_received();
        tick();
        drain(2, 16, 1'b0, 1);
        chk("host_frame_ready", frame_ready, 0);

        // Manual mode: discard then start
        cfg_auto_drain = 1'b0;
        pulse_received();
        tick();
        tick();
        chk("man_ready", frame_ready, 1);
        chk("man_tvalid", m_axis_tvalid, 0);
        chk("man_busy", busy, 0);
        cfg_discard = 1'b1;
        tick();
        cfg_discard = 1'b0;
        chk("man_discard_ready", frame_ready, 0);
        tick();
        chk("man_discard_tvalid", m_axis_tvalid, 0);
        chk("man_discard_busy", busy, 0);
        pulse_received();
        chk("man_ready2", frame_ready, 1);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("man_busy2", busy, 1);
        drain(0, 16, 1'b0, 1);
        chk("man_frame_ready_end", frame_ready, 0);

        // Overflow in READY, then received coinciding with FLUSH completion
        pulse_received();
        pulse_received();
        pulse_received();
        chk("ovf_cnt", overflow_cnt, 2);
        chk("ovf_ready", frame_ready, 1);
        chk("ovf_busy", busy, 0);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        drain(0, 16, 1'b1, 1);
        chk("ovf_done_ready", frame_ready, 1);
        chk("ovf_done_busy", busy, 0);
        chk("ovf_cnt_end", overflow_cnt, 2);
        tick();
        chk("ovf_hold_busy", busy, 0);
        chk("ovf_hold_tvalid", m_axis_tvalid, 0);
        cfg_discard = 1'b1;
        tick();
        cfg_discard = 1'b0;

        // Reset mid-drain after 7 beats
        cfg_auto_drain = 1'b1;
        pulse_received();
        tick();
        drain(0, 7, 1'b0, 0);
        chk("mid_tvalid_before", m_axis_tvalid, 1);
        reset = 1'b1;
        tick();
        chk_all_zero("midrst");
        reset = 1'b0;
        tick();
        chk("midrst_idle_tvalid", m_axis_tvalid, 0);
        pulse_received();
        tick();
        drain(0, 16, 1'b0, 1);
        chk("midrst_frame_ready", frame_ready, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
